// File: rtl/sdram_pkg.sv
// sdram_pkg: shared call-bit indices, FSM encodings and timing constants for the SDRAM controller slice
package sdram_pkg;
  localparam int CALL_WR   = 3;
  localparam int CALL_RD   = 2;
  localparam int CALL_REF  = 1;
  localparam int CALL_INIT = 0;
  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_REF  = 3'd4;
  localparam logic [2:0] S_ACK  = 3'd5;
  localparam logic [15:0] TREF_DEFAULT = 16'd15600;
  localparam int CLK_MHZ = 133;
  function automatic logic [3:0] call_bit(input int idx);
    return 4'b0001 << idx;
  endfunction
endpackage

// File: rtl/sdram_reftimer.sv
// sdram_reftimer: refresh interval counter with a sticky, non-accumulating pending flag
// ports: clk, rst_n (async low), enable (count while high), clear (drop pending), pend (refresh owed)
module sdram_reftimer
  import sdram_pkg::*;
#(
  parameter logic [15:0] TREF = TREF_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic pend
);
  logic [15:0] cnt;
  logic tick;
  assign tick = enable && cnt == TREF - 16'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt  <= '0;
      pend <= 1'b0;
    end else begin
      if (enable) cnt <= tick ? '0 : cnt + 16'd1;
      pend <= !clear && (tick || pend);
    end
endmodule

// File: rtl/sdram_ctrlmod.sv
// sdram_ctrlmod: sequences init, periodic refresh and single-word bus accesses onto sdram_funcmod
// ports: bus side req_i/we_i/sel_i/addr_i/wdata_i -> rdata_o/ack_o, init_done_o;
//        funcmod side call_o/sel_o/addr_o/wdata_o -> done_i/rdata_i
module sdram_ctrlmod
  import sdram_pkg::*;
#(
  parameter logic [15:0] TREF   = TREF_DEFAULT,
  parameter int          ADDR_W = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [3:0]        sel_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ack_o,
  output logic              init_done_o,
  output logic [3:0]        call_o,
  input  logic              done_i,
  output logic [3:0]        sel_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  input  logic [31:0]       rdata_i
);
  logic [2:0] state;
  logic pend;
  sdram_reftimer #(.TREF(TREF)) u_reftimer (
    .clk,
    .rst_n,
    .enable(init_done_o),
    .clear (state == S_IDLE && pend),
    .pend
  );
  // ack_o is high during the first idle cycle after S_ACK, which doubles as the
  // one-cycle guard against a master that drops req_i late.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= S_INIT;
      call_o      <= '0;
      ack_o       <= 1'b0;
      init_done_o <= 1'b0;
      rdata_o     <= '0;
      sel_o       <= '0;
      addr_o      <= '0;
      wdata_o     <= '0;
    end else begin
      ack_o <= state == S_ACK;
      case (state)
        S_INIT:
          if (done_i) begin
            call_o      <= '0;
            init_done_o <= 1'b1;
            state       <= S_IDLE;
          end else call_o <= call_bit(CALL_INIT);
        S_IDLE:
          if (pend) begin
            call_o <= call_bit(CALL_REF);
            state  <= S_REF;
          end else if (req_i && !ack_o) begin
            if (sel_i == 4'h0) state <= S_ACK;
            else begin
              sel_o   <= sel_i;
              addr_o  <= addr_i;
              wdata_o <= wdata_i;
              call_o  <= call_bit(we_i ? CALL_WR : CALL_RD);
              state   <= we_i ? S_WR : S_RD;
            end
          end
        S_WR, S_RD:
          if (done_i) begin
            call_o <= '0;
            if (state == S_RD) rdata_o <= rdata_i;
            state <= S_ACK;
          end
        S_REF:
          if (done_i) begin
            call_o <= '0;
            state  <= S_IDLE;
          end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_sdram_ctrlmod.sv
// tb_sdram_ctrlmod: directed vector table plus refresh/reset corner sequences against a funcmod latency model
module tb_sdram_ctrlmod;
  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [24:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdat;
    logic [3:0]  ecall;
    logic [31:0] erdata;
    int          elat;
  } vec_t;
  localparam int L_INIT = 40, L_REF = 4, L_OP = 5;
  logic clk = 1'b0, rst_n = 1'b0, req_i = 1'b0, we_i = 1'b0, done_i;
  logic [3:0] sel_i = '0, call_o, sel_o;
  logic [24:0] addr_i = '0, addr_o;
  logic [31:0] wdata_i = '0, rdata_i = '0, rdata_o, wdata_o;
  logic ack_o, init_done_o;
  int errs = 0, checks = 0, mcnt;
  vec_t vecs[6];

  always #5 clk = ~clk;

  sdram_ctrlmod #(.TREF(16'd50), .ADDR_W(25)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .sel_i(sel_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .ack_o(ack_o),
    .init_done_o(init_done_o), .call_o(call_o), .done_i(done_i), .sel_o(sel_o),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_i(rdata_i)
  );

  // funcmod stand-in: one-cycle done after a per-call latency, dropped once call is released
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mcnt <= 0;
      done_i <= 1'b0;
    end else if (call_o != 4'b0 && !done_i) begin
      if (mcnt == (call_o[0] ? L_INIT : call_o[1] ? L_REF : L_OP) - 1) begin
        done_i <= 1'b1;
        mcnt <= 0;
      end else mcnt <= mcnt + 1;
    end else begin
      done_i <= 1'b0;
      mcnt <= 0;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errs++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_idle();
    int n = 0;
    while (call_o !== 4'b0010 && n < 200) begin tick(); n++; end
    while (call_o !== 4'b0000 && n < 200) begin tick(); n++; end
    if (n >= 200) timeout("sync_idle");
  endtask

  task automatic wait_ref_rise(output int n);
    logic [3:0] prev;
    n = 0;
    do begin
      prev = call_o;
      tick();
      n++;
    end while (!(call_o == 4'b0010 && prev != 4'b0010) && n < 300);
    if (n >= 300) timeout("ref_rise");
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (!ack_o && n < 300) begin tick(); n++; end
    if (!ack_o) timeout("ack");
  endtask

  task automatic bus_drive(input logic we, input logic [3:0] sel, input logic [24:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdat);
    rdata_i = rdat;
    @(negedge clk);
    we_i = we;
    sel_i = sel;
    addr_i = addr;
    wdata_i = wdata;
    req_i = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    logic d;
    bus_drive(v.we, v.sel, v.addr, v.wdata, v.rdat);
    tick();
    chk("call", {28'b0, call_o}, {28'b0, v.ecall});
    if (v.ecall != 4'b0) begin
      chk("sel_o", {28'b0, sel_o}, {28'b0, v.sel});
      chk("addr_o", {7'b0, addr_o}, {7'b0, v.addr});
      chk("wdata_o", wdata_o, v.wdata);
    end
    n = 1;
    while (!ack_o && n < 40) begin
      d = done_i;
      tick();
      n++;
      if (d) chk("call_rel", {28'b0, call_o}, 32'h0);
    end
    if (!ack_o) timeout("vec_ack");
    chk("lat", n, v.elat);
    chk("rdata", rdata_o, v.erdata);
    tick();
    chk("ack_pulse", {31'b0, ack_o}, 32'h0);
    chk("no_dup", {28'b0, call_o}, 32'h0);
    @(negedge clk);
    req_i = 1'b0;
  endtask

  initial begin
    int n, acks;
    logic early;
    vecs[0] = '{1'b1, 4'hF, 25'h0001234, 32'hDEADBEEF, 32'h0,        4'b1000, 32'h0,        8};
    vecs[1] = '{1'b0, 4'hF, 25'h1000400, 32'h0,        32'hCAFEF00D, 4'b0100, 32'hCAFEF00D, 8};
    vecs[2] = '{1'b1, 4'h0, 25'h0000055, 32'h11111111, 32'h0,        4'b0000, 32'hCAFEF00D, 2};
    vecs[3] = '{1'b1, 4'h3, 25'h1FFFFFF, 32'hA5A5A5A5, 32'h0,        4'b1000, 32'hCAFEF00D, 8};
    vecs[4] = '{1'b0, 4'hC, 25'h0000000, 32'h0,        32'h12345678, 4'b0100, 32'h12345678, 8};
    vecs[5] = '{1'b0, 4'h0, 25'h0000001, 32'h0,        32'h99999999, 4'b0000, 32'h12345678, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_call", {28'b0, call_o}, 32'h0);
    chk("rst_ack", {31'b0, ack_o}, 32'h0);
    chk("rst_init_done", {31'b0, init_done_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_sel", {28'b0, sel_o}, 32'h0);
    chk("rst_addr", {7'b0, addr_o}, 32'h0);
    chk("rst_wdata", wdata_o, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("init_call", {28'b0, call_o}, 32'h1);
    n = 1;
    while (call_o == 4'b0001 && n < 100) begin tick(); n++; end
    chk("init_len", n, L_INIT + 2);
    chk("init_done", {31'b0, init_done_o}, 32'h1);
    chk("init_ack", {31'b0, ack_o}, 32'h0);

    wait_ref_rise(n);
    wait_ref_rise(n);
    chk("ref_period", n, 50);

    for (int i = 0; i < 6; i++) begin
      sync_idle();
      run_vec(vecs[i]);
    end

    // refresh pending when the request arrives: refresh first, then the read
    wait_ref_rise(n);
    repeat (49) tick();
    bus_drive(1'b0, 4'hF, 25'h0000777, 32'h0, 32'h0BADCAFE);
    tick();
    chk("ref_first", {28'b0, call_o}, 32'h2);
    n = 0;
    while (call_o == 4'b0010 && n < 20) begin tick(); n++; end
    chk("ref_then_idle", {28'b0, call_o}, 32'h0);
    tick();
    chk("rd_after_ref", {28'b0, call_o}, 32'h4);
    wait_ack(n);
    chk("a_rdata", rdata_o, 32'h0BADCAFE);
    tick();
    acks = 1 + int'(ack_o);
    @(negedge clk);
    req_i = 1'b0;
    repeat (10) begin tick(); if (ack_o) acks++; end
    chk("one_ack", acks, 1);

    // tick lands on the same edge the request is first seen: request wins, refresh follows
    wait_ref_rise(n);
    repeat (48) tick();
    bus_drive(1'b1, 4'hF, 25'h0ABCDEF, 32'h13579BDF, 32'h0);
    tick();
    chk("req_wins", {28'b0, call_o}, 32'h8);
    wait_ack(n);
    chk("b_rdata_hold", rdata_o, 32'h0BADCAFE);
    tick();
    chk("ref_after_ack", {28'b0, call_o}, 32'h2);
    @(negedge clk);
    req_i = 1'b0;

    // reset in the middle of a read: init reruns and the held request is served afterwards
    sync_idle();
    bus_drive(1'b0, 4'hF, 25'h0000ABC, 32'h0, 32'h77777777);
    tick();
    chk("c_call", {28'b0, call_o}, 32'h4);
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_call", {28'b0, call_o}, 32'h0);
    chk("mid_rst_init_done", {31'b0, init_done_o}, 32'h0);
    chk("mid_rst_rdata", rdata_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("reinit_call", {28'b0, call_o}, 32'h1);
    n = 0;
    early = 1'b0;
    while (!ack_o && n < 300) begin
      tick();
      n++;
      if ((ack_o || call_o[2]) && !init_done_o) early = 1'b1;
    end
    if (!ack_o) timeout("c_ack");
    chk("c_no_early", {31'b0, early}, 32'h0);
    chk("c_rdata", rdata_o, 32'h77777777);
    tick();
    @(negedge clk);
    req_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
